biquad_cascade: RTL and testbench

Parametrised, time-multiplexed cascade of Direct-Form-I biquad IIR sections. It is the successor to the fixed 2nd-order 8-bit notch engine.
- Generalises sample width, coefficient width, fraction bits and section count.
- Adds valid/ready streaming ports, rounding, saturation with sticky status, and a bypass mode.
- Sits between the SDRAM read/write DMA streams. Coefficients and control are set through an Avalon-MM slave.

---
 rtl/biquad_cascade_if.sv | 36 +++
 rtl/biquad_cascade.sv | 241 ++++++++++++++++++++++++
 tb/tb_biquad_cascade.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/biquad_cascade_if.sv
// Streaming and CSR bundle for biquad_cascade.
// slave modport: filter side (consumes input stream and CSR accesses,
//                produces output stream, CSR read data, waitrequest, irq).
// master modport: environment side (DMA streams and Avalon-MM master).
interface biquad_cascade_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 6
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0]        slave_address;
    logic                     slave_read;
    logic [31:0]              slave_readdata;
    logic                     slave_write;
    logic [31:0]              slave_writedata;
    logic                     slave_waitrequest;
    logic                     irq;

    modport slave (
        input  in_valid, in_data, out_ready,
        input  slave_address, slave_read, slave_write, slave_writedata,
        output in_ready, out_valid, out_data,
        output slave_readdata, slave_waitrequest, irq
    );

    modport master (
        output in_valid, in_data, out_ready,
        output slave_address, slave_read, slave_write, slave_writedata,
        input  in_ready, out_valid, out_data,
        input  slave_readdata, slave_waitrequest, irq
    );
endinterface

// File: rtl/biquad_cascade.sv
// Time-multiplexed cascade of Direct-Form-I biquad sections sharing one
// multiplier: five MAC cycles plus one SCALE cycle per section.
// Ports: clk, reset_n (async active-low), bus (biquad_cascade_if.slave):
//   in_valid/in_ready/in_data    input sample stream
//   out_valid/out_ready/out_data output sample stream
//   slave_*                      Avalon-MM CSR/coefficient access
//   irq                          saturation interrupt
// Optional feature macro: BIQUAD_SAT_IRQ_EN (irq and CTRL.irq_en).
module biquad_cascade #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned COEF_W    = 32,
    parameter int unsigned FRAC_BITS = 30,
    parameter int unsigned SECTIONS  = 2,
    parameter int unsigned ADDR_W    = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    biquad_cascade_if.slave bus
);
    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam int unsigned ACC_W  = DATA_W + COEF_W + 3;
    localparam int unsigned SEC_W  = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;

    localparam logic signed [ACC_W-1:0]  RND   = ACC_W'(1) << (FRAC_BITS - 1);
    localparam logic signed [ACC_W-1:0]  Y_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0]  Y_MIN = ~Y_MAX;
    localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(1) << FRAC_BITS;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_SCALE, S_OUT} state_t;

    state_t                    state;
    logic [2:0]                k;
    logic [SEC_W-1:0]          sec;
    logic signed [ACC_W-1:0]   acc;
    logic signed [DATA_W-1:0]  x_cur;
    logic signed [DATA_W-1:0]  x1 [SECTIONS];
    logic signed [DATA_W-1:0]  x2 [SECTIONS];
    logic signed [DATA_W-1:0]  y1 [SECTIONS];
    logic signed [DATA_W-1:0]  y2 [SECTIONS];
    logic signed [COEF_W-1:0]  coef [SECTIONS][5];
    logic                      enable;
    logic                      sat_sticky;
    logic [31:0]               out_count;
    logic [31:0]               sat_count;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic signed [DATA_W-1:0]  out_data_q;
    logic [31:0]               readdata_q;
    logic                      irq_en_rd;

    // Shared-multiplier datapath: operand select, accumulate, round, clamp.
    logic signed [COEF_W-1:0]  mac_coef;
    logic signed [DATA_W-1:0]  mac_data;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [DATA_W-1:0]  y_sat;
    logic                      clamp;

    always_comb begin
        mac_coef = coef[sec][0];
        mac_data = x_cur;
        case (k)
            3'd1:    begin mac_coef = coef[sec][1]; mac_data = x1[sec]; end
            3'd2:    begin mac_coef = coef[sec][2]; mac_data = x2[sec]; end
            3'd3:    begin mac_coef = coef[sec][3]; mac_data = y1[sec]; end
            3'd4:    begin mac_coef = coef[sec][4]; mac_data = y2[sec]; end
            default: ;
        endcase
        prod     = PROD_W'(mac_coef) * PROD_W'(mac_data);
        // Feedback terms (a1, a2) are subtracted.
        acc_next = (k >= 3'd3) ? acc - ACC_W'(prod) : acc + ACC_W'(prod);
        shifted  = (acc + RND) >>> FRAC_BITS;
        clamp    = 1'b0;
        y_sat    = DATA_W'(shifted);
        if (shifted > Y_MAX) begin
            y_sat = DATA_W'(Y_MAX);
            clamp = 1'b1;
        end else if (shifted < Y_MIN) begin
            y_sat = DATA_W'(Y_MIN);
            clamp = 1'b1;
        end
    end

    // CSR address decode, write stall and read mux.
    logic [ADDR_W-1:0] off;
    logic              coef_hit;
    logic [SEC_W-1:0]  cs;
    logic [2:0]        ck;
    logic              stall_c;
    logic              wr_en;
    logic [31:0]       rd_mux;

    always_comb begin
        off      = bus.slave_address - ADDR_W'(8);
        coef_hit = (bus.slave_address >= ADDR_W'(8)) && (off[2:0] < 3'd5) &&
                   ((off >> 3) < ADDR_W'(SECTIONS));
        cs       = SEC_W'(off >> 3);
        ck       = off[2:0];
        // Stall is combinational so the master sees it in the request cycle.
        stall_c  = bus.slave_write && (state != S_IDLE) &&
                   ((bus.slave_address == '0) || coef_hit);
        wr_en    = bus.slave_write && !stall_c;
        rd_mux   = 32'd0;
        case (bus.slave_address)
            ADDR_W'(0): rd_mux = {29'd0, irq_en_rd, 1'b0, enable};
            ADDR_W'(1): rd_mux = {30'd0, sat_sticky, state != S_IDLE};
            ADDR_W'(2): rd_mux = out_count;
            ADDR_W'(3): rd_mux = sat_count;
            default:    if (coef_hit) rd_mux = 32'(coef[cs][ck]);
        endcase
    end

`ifdef BIQUAD_SAT_IRQ_EN
    logic irq_en;
    logic irq_q;
    assign irq_en_rd = irq_en;
    assign bus.irq   = irq_q;
`else
    assign irq_en_rd = 1'b0;
    assign bus.irq   = 1'b0;
`endif

    // Sequencer, history/coefficient storage and CSR registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            k           <= '0;
            sec         <= '0;
            acc         <= '0;
            x_cur       <= '0;
            enable      <= 1'b1;
            sat_sticky  <= 1'b0;
            out_count   <= '0;
            sat_count   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            readdata_q  <= '0;
            for (int s = 0; s < int'(SECTIONS); s++) begin
                x1[s] <= '0;
                x2[s] <= '0;
                y1[s] <= '0;
                y2[s] <= '0;
                coef[s][0] <= UNITY;
                for (int c = 1; c < 5; c++) coef[s][c] <= '0;
            end
`ifdef BIQUAD_SAT_IRQ_EN
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_q <= 1'b0;
                        if (enable) begin
                            x_cur <= bus.in_data;
                            sec   <= '0;
                            k     <= '0;
                            acc   <= '0;
                            state <= S_MAC;
                        end else begin
                            out_data_q  <= bus.in_data;
                            out_valid_q <= 1'b1;
                            state       <= S_OUT;
                        end
                    end
                end
                S_MAC: begin
                    acc <= acc_next;
                    if (k == 3'd4) state <= S_SCALE;
                    else           k     <= k + 3'd1;
                end
                S_SCALE: begin
                    x2[sec] <= x1[sec];
                    x1[sec] <= x_cur;
                    y2[sec] <= y1[sec];
                    y1[sec] <= y_sat;
                    if (clamp) sat_count <= sat_count + 32'd1;
                    if (sec == SEC_W'(SECTIONS - 1)) begin
                        out_data_q  <= y_sat;
                        out_valid_q <= 1'b1;
                        state       <= S_OUT;
                    end else begin
                        sec   <= sec + SEC_W'(1);
                        x_cur <= y_sat;
                        k     <= '0;
                        acc   <= '0;
                        state <= S_MAC;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_count   <= out_count + 32'd1;
                        in_ready_q  <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
            endcase

            // Read data holds when a write shares the cycle.
            if (bus.slave_read && !bus.slave_write) readdata_q <= rd_mux;

            if (wr_en) begin
                if (bus.slave_address == ADDR_W'(0)) begin
                    enable <= bus.slave_writedata[0];
`ifdef BIQUAD_SAT_IRQ_EN
                    irq_en <= bus.slave_writedata[2];
`endif
                    // CTRL writes only commit in IDLE, so no SCALE update races this.
                    if (bus.slave_writedata[1]) begin
                        for (int s = 0; s < int'(SECTIONS); s++) begin
                            x1[s] <= '0;
                            x2[s] <= '0;
                            y1[s] <= '0;
                            y2[s] <= '0;
                        end
                    end
                end
                if (bus.slave_address == ADDR_W'(1) && bus.slave_writedata[1])
                    sat_sticky <= 1'b0;
                if (coef_hit) coef[cs][ck] <= bus.slave_writedata[COEF_W-1:0];
            end

            // A new clamp wins over a same-cycle clear.
            if (state == S_SCALE && clamp) sat_sticky <= 1'b1;

`ifdef BIQUAD_SAT_IRQ_EN
            irq_q <= sat_sticky & irq_en;
`endif
        end
    end

    assign bus.in_ready          = in_ready_q;
    assign bus.out_valid         = out_valid_q;
    assign bus.out_data          = out_data_q;
    assign bus.slave_readdata    = readdata_q;
    assign bus.slave_waitrequest = stall_c;
endmodule

// File: tb/tb_biquad_cascade.sv
// Directed self-checking bench for biquad_cascade (DATA_W=16, COEF_W=32,
// FRAC_BITS=30, SECTIONS=2). Honours BIQUAD_SAT_IRQ_EN when defined.
module tb_biquad_cascade;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   fails  = 0;
    logic [31:0] rd;

    biquad_cascade_if #(.DATA_W(16), .ADDR_W(6)) bus ();

    biquad_cascade #(
        .DATA_W(16), .COEF_W(32), .FRAC_BITS(30), .SECTIONS(2), .ADDR_W(6)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic csr_write(input string tag, input logic [5:0] a, input logic [31:0] d);
        int n = 0;
        bus.slave_address   = a;
        bus.slave_writedata = d;
        bus.slave_write     = 1'b1;
        @(negedge clk);
        while (bus.slave_waitrequest && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check({tag, " write timeout"}, 32'(n), 32'd0);
        @(posedge clk);
        #1;
        bus.slave_write = 1'b0;
    endtask

    task automatic csr_read(input logic [5:0] a, output logic [31:0] d);
        bus.slave_address = a;
        bus.slave_read    = 1'b1;
        @(posedge clk);
        #1;
        bus.slave_read = 1'b0;
        d = bus.slave_readdata;
    endtask

    task automatic send(input string tag, input int x);
        int n = 0;
        bus.in_data  = 16'(x);
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check({tag, " accept timeout"}, 32'(n), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Sends x, counts edges after the accept edge until out_valid, checks data.
    task automatic run(input string tag, input int x, input int exp_y, input int exp_lat);
        int lat = 0;
        send(tag, x);
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " data"}, 32'(bus.out_data), 32'(exp_y));
        if (bus.out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.in_valid        = 1'b0;
        bus.in_data         = '0;
        bus.out_ready       = 1'b1;
        bus.slave_address   = '0;
        bus.slave_read      = 1'b0;
        bus.slave_write     = 1'b0;
        bus.slave_writedata = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_data", 32'(bus.out_data), 32'd0);
        check("rst readdata", bus.slave_readdata, 32'd0);
        check("rst waitreq", 32'(bus.slave_waitrequest), 32'd0);
        check("rst irq", 32'(bus.irq), 32'd0);
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        csr_read(6'd0, rd);  check("rst ctrl", rd, 32'h1);
        csr_read(6'd8, rd);  check("rst s0 b0", rd, 32'h4000_0000);
        csr_read(6'd19, rd); check("rst s1 a1", rd, 32'h0);
        csr_read(6'd2, rd);  check("rst outcount", rd, 32'h0);

        // Identity
        run("ident", 1000, 1000, 12);
        csr_read(6'd2, rd);  check("ident outcount", rd, 32'd1);

        // Bypass, then re-enable
        csr_write("bypass", 6'd0, 32'h0);
        run("bypass", -5, -5, 0);
        csr_write("enable", 6'd0, 32'h1);
        run("reenable", 0, 0, 12);
        csr_read(6'd2, rd);  check("bypass outcount", rd, 32'd3);

        // Saturation, both rails
        csr_write("sat b0", 6'd8, 32'h7FFF_FFFF);
        run("sat pos", 30000, 32767, 12);
        csr_read(6'd1, rd);  check("sat status", rd, 32'h2);
        csr_read(6'd3, rd);  check("sat count1", rd, 32'd1);
        run("sat neg", -30000, -32768, 12);
        csr_read(6'd3, rd);  check("sat count2", rd, 32'd2);
`ifdef BIQUAD_SAT_IRQ_EN
        check("irq off", 32'(bus.irq), 32'd0);
        csr_write("irq_en", 6'd0, 32'h5);
        csr_read(6'd0, rd);  check("ctrl irq_en", rd, 32'h5);
        check("irq on", 32'(bus.irq), 32'd1);
        csr_write("w1c", 6'd1, 32'h2);
        @(posedge clk);
        #1;
        check("irq cleared", 32'(bus.irq), 32'd0);
        csr_write("irq_dis", 6'd0, 32'h1);
`else
        csr_write("irq_en", 6'd0, 32'h5);
        csr_read(6'd0, rd);  check("ctrl bit2 ignored", rd, 32'h1);
        check("irq tied", 32'(bus.irq), 32'd0);
        csr_write("w1c", 6'd1, 32'h2);
`endif
        csr_read(6'd1, rd);  check("sticky cleared", rd, 32'h0);

        // Rounding half up at b0=0.5
        csr_write("half b0", 6'd8, 32'h2000_0000);
        run("round pos", 3, 2, 12);
        run("round neg", -3, -1, 12);

        // Recursion y = x + 0.5*y1 in section 0
        csr_write("rec b0", 6'd8, 32'h4000_0000);
        csr_write("rec a1", 6'd11, 32'hE000_0000);
        csr_read(6'd11, rd); check("rec a1 readback", rd, 32'hE000_0000);
        csr_write("clear", 6'd0, 32'h3);
        run("imp0", 1024, 1024, 12);
        run("imp1", 0, 512, 12);
        run("imp2", 0, 256, 12);
        run("imp3", 0, 128, 12);
        csr_write("rec a1 off", 6'd11, 32'h0);

        // Back-pressure with a coefficient write stalled behind it
        bus.out_ready = 1'b0;
        run("bp", 500, 500, 12);
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                bus.slave_address   = 6'd20;
                bus.slave_writedata = 32'h0000_1234;
                bus.slave_write     = 1'b1;
            end
            @(posedge clk);
            #1;
            check("bp valid", 32'(bus.out_valid), 32'd1);
            check("bp data", 32'(bus.out_data), 32'd500);
            check("bp in_ready", 32'(bus.in_ready), 32'd0);
            if (i >= 10) check("bp waitreq", 32'(bus.slave_waitrequest), 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp released", 32'(bus.out_valid), 32'd0);
        check("bp waitreq idle", 32'(bus.slave_waitrequest), 32'd0);
        @(posedge clk);
        #1;
        bus.slave_write = 1'b0;
        csr_read(6'd20, rd); check("bp coef readback", rd, 32'h0000_1234);
        csr_read(6'd2, rd);  check("bp outcount", rd, 32'd12);

        // Reset in the middle of MAC
        csr_write("pre b0", 6'd8, 32'h2000_0000);
        send("midrst", 99);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        csr_read(6'd8, rd);  check("midrst s0 b0", rd, 32'h4000_0000);
        csr_read(6'd20, rd); check("midrst s1 a2", rd, 32'h0);
        csr_read(6'd2, rd);  check("midrst outcount", rd, 32'd0);
        csr_read(6'd1, rd);  check("midrst status", rd, 32'd0);
        run("after rst", 77, 77, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
